// File: rtl/lzc_norm_seq.sv
// Multi-cycle leading-zero / leading-one counter and left normaliser.
// Scans the operand MSB-first, CHUNK bits per cycle, and stops at the first
// chunk that contains the sought bit. Valid/ready handshakes on both sides.
module lzc_norm_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_all,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_scan;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_count;
  logic [IW-1:0]    r_idx;
  logic             r_out_valid;
  logic [CW-1:0]    r_out_count;
  logic [WIDTH-1:0] r_out_norm;
  logic             r_out_all;
  logic             r_busy;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_scan_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [IW-1:0]    w_idx_nxt;
  logic [CW-1:0]    w_out_count_nxt;
  logic [WIDTH-1:0] w_out_norm_nxt;
  logic             w_out_all_nxt;

  // Datapath helpers
  logic [CHUNK-1:0] w_chunk;
  logic             w_chunk_zero;
  logic             w_last;
  logic [CW-1:0]    w_lz;
  logic [CW-1:0]    w_count_hit;
  logic [WIDTH-1:0] w_scan_load;
  logic             w_accept;

  // Leading zeros of a chunk; only meaningful for a nonzero chunk.
  function automatic logic [CW-1:0] chunk_lz(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    n = CW'(CHUNK);
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (c[i]) n = CW'(CHUNK - 1 - 32'(i));
    end
    return n;
  endfunction

  // Top chunk of the scan register and the count if the search ends here
  assign w_chunk      = r_scan[WIDTH-1 -: CHUNK];
  assign w_chunk_zero = (w_chunk == '0);
  assign w_last       = (r_idx == IW'(NCHUNK - 1));
  assign w_lz         = chunk_lz(w_chunk);
  assign w_count_hit  = r_count + w_lz;

  // Leading-one search is turned into a leading-zero search by inversion
  assign w_scan_load = in_mode ? ~in_data : in_data;

  // Ready in IDLE, or in DONE when the result is being taken this cycle
  assign in_ready = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_scan_nxt      = r_scan;
    w_data_nxt      = r_data;
    w_count_nxt     = r_count;
    w_idx_nxt       = r_idx;
    w_out_count_nxt = r_out_count;
    w_out_norm_nxt  = r_out_norm;
    w_out_all_nxt   = r_out_all;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_scan_nxt  = w_scan_load;
          w_data_nxt  = in_data;
          w_count_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!w_chunk_zero) begin
          w_out_count_nxt = w_count_hit;
          w_out_norm_nxt  = r_data << w_count_hit;
          w_out_all_nxt   = 1'b0;
          w_state_nxt     = S_DONE;
        end else if (w_last) begin
          w_out_count_nxt = CW'(WIDTH);
          w_out_norm_nxt  = '0;
          w_out_all_nxt   = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_count_nxt = r_count + CW'(CHUNK);
          w_scan_nxt  = r_scan << CHUNK;
          w_idx_nxt   = r_idx + IW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          if (w_accept) begin
            w_scan_nxt  = w_scan_load;
            w_data_nxt  = in_data;
            w_count_nxt = '0;
            w_idx_nxt   = '0;
            w_state_nxt = S_SCAN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_scan      <= '0;
      r_data      <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_norm  <= '0;
      r_out_all   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_scan      <= w_scan_nxt;
      r_data      <= w_data_nxt;
      r_count     <= w_count_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      r_out_count <= w_out_count_nxt;
      r_out_norm  <= w_out_norm_nxt;
      r_out_all   <= w_out_all_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_norm  = r_out_norm;
  assign out_all   = r_out_all;
  assign busy      = r_busy;

endmodule

// File: tb/tb_lzc_norm_seq.sv
// Bench for lzc_norm_seq: four instances (CHUNK = 8, 1, 4, 32), directed
// cases on the CHUNK=8 instance, then randomized traffic on each instance
// checked against a behavioural model by a single compare process.
module tb_lzc_norm_seq;

  localparam int unsigned W    = 32;
  localparam int unsigned CWT  = 6;
  localparam int          NDUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           d_valid [NDUT];
  logic           d_ready [NDUT];
  logic           d_mode  [NDUT];
  logic [W-1:0]   d_data  [NDUT];
  logic           q_in_ready [NDUT];
  logic           q_valid    [NDUT];
  logic           q_all      [NDUT];
  logic           q_busy     [NDUT];
  logic [CWT-1:0] q_count    [NDUT];
  logic [W-1:0]   q_norm     [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    lzc_norm_seq #(
      .WIDTH(W),
      .CHUNK((g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (d_valid[g]),
      .in_ready  (q_in_ready[g]),
      .in_data   (d_data[g]),
      .in_mode   (d_mode[g]),
      .out_valid (q_valid[g]),
      .out_ready (d_ready[g]),
      .out_count (q_count[g]),
      .out_norm  (q_norm[g]),
      .out_all   (q_all[g]),
      .busy      (q_busy[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;
  int cyc      = 0;
  bit front_seen = 1'b0;

  typedef struct {
    int           count;
    logic [W-1:0] norm;
    bit           all;
    int           acc;
    int           k;
  } exp_t;
  exp_t exp_q[$];

  function automatic int chunk_of(input int s);
    case (s)
      0:       return 8;
      1:       return 1;
      2:       return 4;
      default: return 32;
    endcase
  endfunction

  // Count leading bits equal to the mode value, MSB first
  function automatic int ref_count(input logic [W-1:0] d, input logic m);
    int n = 0;
    while (n < int'(W) && d[W-1-n] == m) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] ref_norm(input logic [W-1:0] d, input int n);
    if (n >= int'(W)) return '0;
    return d << n;
  endfunction

  function automatic int ref_lat(input int n, input int ch);
    int a = n / ch + 1;
    int b = int'(W) / ch;
    return (a < b) ? a : b;
  endfunction

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t inst=%0d)", name, act, exp, $time, sel);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: checks the selected instance every cycle against the model
  always @(negedge clk) begin : p_cmp
    exp_t e;
    if (!rst_n) begin
      chk_eq("rst_out_valid", 64'(q_valid[sel]), 64'(0));
      chk_eq("rst_busy",      64'(q_busy[sel]), 64'(0));
      chk_eq("rst_in_ready",  64'(q_in_ready[sel]), 64'(0));
      chk_eq("rst_count",     64'(q_count[sel]), 64'(0));
      chk_eq("rst_norm",      64'(q_norm[sel]), 64'(0));
      chk_eq("rst_all",       64'(q_all[sel]), 64'(0));
      exp_q.delete();
      front_seen = 1'b0;
    end else begin
      chk_eq("in_ready", 64'(q_in_ready[sel]),
             64'((exp_q.size() == 0) || (q_valid[sel] && d_ready[sel])));
      chk_eq("busy", 64'(q_busy[sel]), 64'(exp_q.size() != 0));
      if (q_valid[sel]) begin
        if (exp_q.size() == 0) begin
          chk_eq("valid_with_no_op", 64'(exp_q.size()), 64'(1));
        end else begin
          chk_eq("count", 64'(q_count[sel]), 64'(exp_q[0].count));
          chk_eq("norm",  64'(q_norm[sel]),  64'(exp_q[0].norm));
          chk_eq("all",   64'(q_all[sel]),   64'(exp_q[0].all));
          if (!front_seen) begin
            chk_eq("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].k));
            front_seen = 1'b1;
          end
        end
      end else if (exp_q.size() != 0 && !front_seen && (cyc - exp_q[0].acc) >= exp_q[0].k) begin
        chk_eq("out_valid_due", 64'(q_valid[sel]), 64'(1));
        front_seen = 1'b1;
      end
      if (q_valid[sel] && d_ready[sel] && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        front_seen = 1'b0;
      end
      if (d_valid[sel] && q_in_ready[sel]) begin
        e.count = ref_count(d_data[sel], d_mode[sel]);
        e.norm  = ref_norm(d_data[sel], e.count);
        e.all   = (e.count == int'(W));
        e.acc   = cyc + 1;
        e.k     = ref_lat(e.count, chunk_of(sel));
        exp_q.push_back(e);
      end
    end
  end

  // Offer an operand on the selected instance and hold it until accepted
  task automatic offer(input logic [W-1:0] d, input logic m);
    int n = 0;
    d_valid[sel] = 1'b1;
    d_data[sel]  = d;
    d_mode[sel]  = m;
    @(negedge clk);
    while (!q_in_ready[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk_eq("in_ready_timeout", 64'(q_in_ready[sel]), 64'(1));
    @(posedge clk);
    #1;
    d_valid[sel] = 1'b0;
  endtask

  // Wait for the result following an accept and check literal expectations
  task automatic wait_result(input int exp_cnt, input logic [W-1:0] exp_norm,
                             input bit exp_all, input int exp_lat);
    int n = 0;
    while (!q_valid[sel] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_eq("dir_latency", 64'(n), 64'(exp_lat));
    chk_eq("dir_count",   64'(q_count[sel]), 64'(exp_cnt));
    chk_eq("dir_norm",    64'(q_norm[sel]), 64'(exp_norm));
    chk_eq("dir_all",     64'(q_all[sel]), 64'(exp_all));
  endtask

  task automatic gen_operand(output logic [W-1:0] d, output logic m);
    logic [W-1:0] base;
    int sh;
    sh   = $urandom_range(0, 32);
    base = (sh == 32) ? '0 : (W'($urandom) >> sh);
    m    = 1'($urandom_range(0, 1));
    d    = m ? ~base : base;
    if ($urandom_range(0, 7) == 0) d = W'($urandom);
  endtask

  // Randomized traffic with random ready stalls on one instance
  task automatic run_random(input int s, input int nops);
    int issued = 0;
    int guard  = 0;
    bit acc;
    logic [W-1:0] d;
    logic m;
    sel = s;
    d_valid[s] = 1'b0;
    d_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    while (issued < nops) begin
      @(negedge clk);
      acc = d_valid[s] && q_in_ready[s];
      @(posedge clk);
      #1;
      if (acc) issued++;
      if (acc || !d_valid[s]) begin
        if ($urandom_range(0, 3) != 0) begin
          gen_operand(d, m);
          d_valid[s] = 1'b1;
          d_data[s]  = d;
          d_mode[s]  = m;
        end else begin
          d_valid[s] = 1'b0;
        end
      end
      d_ready[s] = ($urandom_range(0, 3) != 0);
    end
    d_valid[s] = 1'b0;
    d_ready[s] = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    chk_eq("drain", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      d_valid[g] = 1'b0;
      d_ready[g] = 1'b0;
      d_mode[g]  = 1'b0;
      d_data[g]  = '0;
    end
    sel = 0;

    // Hand-computed values that pin the reference model
    chk_eq("model_cnt_fff01234",  64'(ref_count(32'hFFF01234, 1'b1)), 64'(12));
    chk_eq("model_norm_fff01234", 64'(ref_norm(32'hFFF01234, 12)), 64'h01234000);
    chk_eq("model_cnt_1",         64'(ref_count(32'h00000001, 1'b0)), 64'(31));
    chk_eq("model_cnt_0",         64'(ref_count(32'h00000000, 1'b0)), 64'(32));
    chk_eq("model_lat_31_c8",     64'(ref_lat(ref_count(32'h00000001, 1'b0), 8)), 64'(4));
    chk_eq("model_lat_32_c1",     64'(ref_lat(ref_count(32'h00000000, 1'b0), 1)), 64'(32));

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases on the CHUNK=8 instance
    d_ready[0] = 1'b1;
    offer(32'h80000000, 1'b0); wait_result(0,  32'h80000000, 1'b0, 1);
    offer(32'h00000001, 1'b0); wait_result(31, 32'h80000000, 1'b0, 4);
    offer(32'h00000000, 1'b0); wait_result(32, 32'h00000000, 1'b1, 4);
    offer(32'hFFF01234, 1'b1); wait_result(12, 32'h01234000, 1'b0, 2);
    offer(32'hFFFFFFFF, 1'b1); wait_result(32, 32'h00000000, 1'b1, 4);

    // Back-pressure: result held, new operand offered but refused
    @(posedge clk);
    #1;
    d_ready[0] = 1'b0;
    offer(32'h80000000, 1'b0); wait_result(0, 32'h80000000, 1'b0, 1);
    d_valid[0] = 1'b1;
    d_data[0]  = 32'h00F00000;
    d_mode[0]  = 1'b0;
    repeat (5) begin
      chk_eq("hold_valid",    64'(q_valid[0]), 64'(1));
      chk_eq("hold_count",    64'(q_count[0]), 64'(0));
      chk_eq("hold_norm",     64'(q_norm[0]), 64'h80000000);
      chk_eq("hold_in_ready", 64'(q_in_ready[0]), 64'(0));
      @(posedge clk);
      #1;
    end
    d_ready[0] = 1'b1;
    #1;
    chk_eq("bp_in_ready", 64'(q_in_ready[0]), 64'(1));
    @(posedge clk);
    #1;
    d_valid[0] = 1'b0;
    chk_eq("bp_valid_drop", 64'(q_valid[0]), 64'(0));
    chk_eq("bp_busy",       64'(q_busy[0]), 64'(1));
    wait_result(8, 32'hF0000000, 1'b0, 2);

    // Reset in the middle of a scan
    @(posedge clk);
    #1;
    offer(32'h00000001, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_valid",    64'(q_valid[0]), 64'(0));
    chk_eq("midrst_busy",     64'(q_busy[0]), 64'(0));
    chk_eq("midrst_in_ready", 64'(q_in_ready[0]), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("postrst_valid", 64'(q_valid[0]), 64'(0));
    offer(32'h40000000, 1'b0); wait_result(1, 32'h80000000, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic on every instance
    run_random(0, 1500);
    run_random(1, 1200);
    run_random(2, 2500);
    run_random(3, 3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
